path_replayer: RTL and testbench
================================

// Module: path_replayer
// PURPOSE
//  Sits directly downstream of the maze datapath's checklist stack and drains the solved path one
//  2-bit move at a time (read pulse + Move/empty). Replays the moves from origin (0,0) and emits
//  one registered coordinate step per move over a valid/ready interface (display/robot driver).
//  Signals done once the checklist reports empty.
// PARAMETERS
//  COORD_W   4   width of X/Y coordinates; grid is 2^COORD_W per axis
//  IDX_W     8   width of step index counter; saturates at all-ones
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  rst         in   1        synchronous, active-low reset
//  start       in   1        begin replay; honoured only in IDLE or DONE
//  move        in   2        current checklist top; valid whenever move_empty=0
//  move_empty  in   1        checklist empty (finished reading)
//  move_rd     out  1        one-cycle pop pulse to checklist (combinational from FSM)
//  step_valid  out  1        step outputs valid; held until accepted
//  step_ready  in   1        downstream accepts step when step_valid&step_ready
//  step_x      out  COORD_W  X after this move
//  step_y      out  COORD_W  Y after this move
//  step_dir    out  2        move that produced this step
//  step_idx    out  IDX_W    zero-based index of this step
//  done        out  1        replay finished; sticky until next start
//  err         out  1        path left the grid (bounds-check build only; else tied 0)
// BEHAVIOUR
//  - Move encoding: 00 Y+1, 01 X+1, 10 X-1, 11 Y-1 (X moves when dir[1]^dir[0]; dir[1]=1 decrements).
//  - Reset (rst=0 at edge): state IDLE; x=y=0, step_idx=0, step_dir=0, step_valid=0, done=0, err=0;
//    move_rd=0 while in reset. Reset mid-replay abandons the path; no partial pop is issued.
//  - IDLE: outputs held; start=1 -> clear x,y,idx,done,err -> FETCH.
//  - FETCH: if move_empty=1 -> DONE (done<=1). Else move_rd=1 this cycle only, move sampled the same
//    cycle (pop takes effect at this edge); step_dir<=move, step_x/y<=next coord, step_valid<=1 -> STEP.
//  - STEP: outputs stable while step_valid=1 & step_ready=0. On accept: step_valid<=0, step_idx<=idx+1
//    (saturating at 2^IDX_W-1) -> FETCH. First emitted step has step_idx=0.
//  - DONE: done=1, step_valid=0, move_rd=0; start=1 -> restart as from IDLE (clears done/err).
//  - start while FETCH/STEP is ignored. Latency: first step_valid 2 cycles after start edge;
//    max throughput one step per 2 cycles with step_ready tied high.
//  - Empty checklist at start: DONE one cycle after FETCH, zero steps emitted, x=y=0.
//  - Exactly one move_rd per emitted step; never asserted when move_empty=1.
// CONFIGURATION
//  PATH_REPLAYER_BOUNDS_CHECK_EN defined: in FETCH, a move leaving [0,2^COORD_W-1] on either axis
//    is still popped (move_rd=1) but no step is emitted; err<=1, done<=1, state -> DONE; x/y keep
//    last in-range values. err sticky until start or reset.
//  Not defined: coordinates wrap modulo 2^COORD_W, err constant 0, replay always runs to empty.
// STRUCTURE
//  - Shared package maze_pkg: DIR_YINC=2'b00, DIR_XINC=2'b01, DIR_XDEC=2'b10, DIR_YDEC=2'b11;
//    FSM state typedef (IDLE, FETCH, STEP, DONE); COORD_W default constant shared with datapath.
//  - One sub-module: coord_stepper (combinational next-x/next-y from dir plus out-of-range flag),
//    reusable by the datapath side; FSM, index counter and output registers stay in top.
// TESTING
//  1 Reset: rst=0 two cycles mid-STEP -> all outputs 0, state IDLE, no move_rd pulse.
//  2 Path 01,01,00,00 (empty after 4), step_ready=1 -> steps (1,0),(2,0),(2,1),(2,2), idx 0..3,
//    4 move_rd pulses, done=1 after final FETCH, err=0.
//  3 Backpressure: step_ready=0 for 5 cycles on step 1 -> step_x/y/dir/idx stable, no extra move_rd.
//  4 Empty at start: move_empty=1, start=1 -> done=1 two cycles later, step_valid never 1.
//  5 Move 10 first from (0,0): BOUNDS_CHECK_EN -> one move_rd, no step, err=1, done=1;
//    without macro -> step (15,0), err=0.
//  6 start pulsed during STEP ignored; start in DONE restarts with idx=0, done/err cleared.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze types: move encodings, replay FSM states and default coordinate width.
package maze_pkg;

  localparam int unsigned CoordWDefault = 4;

  localparam logic [1:0] DIR_YINC = 2'b00;
  localparam logic [1:0] DIR_XINC = 2'b01;
  localparam logic [1:0] DIR_XDEC = 2'b10;
  localparam logic [1:0] DIR_YDEC = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StStep,
    StDone
  } replay_state_e;

endpackage

// File: rtl/coord_stepper.sv
// Combinational single-move coordinate update with an off-grid flag.
module coord_stepper
  import maze_pkg::*;
#(
  parameter int unsigned COORD_W = CoordWDefault
) (
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [1:0]         dir_i,
  output logic [COORD_W-1:0] next_x_o,
  output logic [COORD_W-1:0] next_y_o,
  output logic               oob_o
);

  localparam logic [COORD_W-1:0] One = {{(COORD_W-1){1'b0}}, 1'b1};

  // Next coordinates wrap naturally; oob_o flags when that wrap happened.
  always_comb begin
    next_x_o = x_i;
    next_y_o = y_i;
    oob_o    = 1'b0;
    unique case (dir_i)
      DIR_YINC: begin
        next_y_o = y_i + One;
        oob_o    = &y_i;
      end
      DIR_XINC: begin
        next_x_o = x_i + One;
        oob_o    = &x_i;
      end
      DIR_XDEC: begin
        next_x_o = x_i - One;
        oob_o    = (x_i == '0);
      end
      DIR_YDEC: begin
        next_y_o = y_i - One;
        oob_o    = (y_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/path_replayer.sv
// Drains the solved path from the checklist stack and replays it as coordinate steps.
// Define PATH_REPLAYER_BOUNDS_CHECK_EN to abort with err when a move leaves the grid.
module path_replayer
  import maze_pkg::*;
#(
  parameter int unsigned COORD_W = CoordWDefault,
  parameter int unsigned IDX_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         move,
  input  logic               move_empty,
  output logic               move_rd,
  output logic               step_valid,
  input  logic               step_ready,
  output logic [COORD_W-1:0] step_x,
  output logic [COORD_W-1:0] step_y,
  output logic [1:0]         step_dir,
  output logic [IDX_W-1:0]   step_idx,
  output logic               done,
  output logic               err
);

  localparam logic [IDX_W-1:0] IdxOne = {{(IDX_W-1){1'b0}}, 1'b1};

  replay_state_e      state_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [1:0]         dir_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q, done_q, err_q;

  logic [COORD_W-1:0] next_x, next_y;
  logic               oob, oob_abort;

  coord_stepper #(
    .COORD_W(COORD_W)
  ) u_coord_stepper (
    .x_i     (x_q),
    .y_i     (y_q),
    .dir_i   (move),
    .next_x_o(next_x),
    .next_y_o(next_y),
    .oob_o   (oob)
  );

`ifdef PATH_REPLAYER_BOUNDS_CHECK_EN
  assign oob_abort = oob;
`else
  logic unused_oob;
  assign unused_oob = oob;
  assign oob_abort  = 1'b0;
`endif

  // Pop is gated by reset so an abandoned replay never consumes a move.
  assign move_rd = rst && (state_q == StFetch) && !move_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          if (move_empty) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (oob_abort) begin
            // Move is consumed but coordinates keep the last in-range point.
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            dir_q   <= move;
            x_q     <= next_x;
            y_q     <= next_y;
            valid_q <= 1'b1;
            state_q <= StStep;
          end
        end
        StStep: begin
          if (step_ready) begin
            valid_q <= 1'b0;
            idx_q   <= (idx_q == {IDX_W{1'b1}}) ? idx_q : idx_q + IdxOne;
            state_q <= StFetch;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign step_valid = valid_q;
  assign step_x     = x_q;
  assign step_y     = y_q;
  assign step_dir   = dir_q;
  assign step_idx   = idx_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_path_replayer.sv
// Scoreboard bench for path_replayer with a queue-backed checklist model.
module tb_path_replayer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] move;
  logic       move_empty;
  logic       move_rd;
  logic       step_valid;
  logic       step_ready;
  logic [3:0] step_x;
  logic [3:0] step_y;
  logic [1:0] step_dir;
  logic [7:0] step_idx;
  logic       done;
  logic       err;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] dir;
    logic [7:0] idx;
  } step_t;

  step_t      exp_q[$];
  int         total;
  int         bad;
  int         rd_seen;
  int         rd0;
  int         pop_cnt;
  int         path_base;
  int         path_len;
  int         rd_idx;
  logic [1:0] path_mem[16];

  path_replayer #(
    .COORD_W(4),
    .IDX_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .move      (move),
    .move_empty(move_empty),
    .move_rd   (move_rd),
    .step_valid(step_valid),
    .step_ready(step_ready),
    .step_x    (step_x),
    .step_y    (step_y),
    .step_dir  (step_dir),
    .step_idx  (step_idx),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Checklist model: the top of stack advances on each pop pulse.
  assign rd_idx     = pop_cnt - path_base;
  assign move_empty = (rd_idx >= path_len);
  assign move       = move_empty ? 2'b00 : path_mem[rd_idx[3:0]];

  always @(posedge clk) begin
    if (move_rd) pop_cnt <= pop_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic load_path(input logic [15:0] mv, input int len);
    for (int i = 0; i < 8; i++) path_mem[i] = mv[2*i +: 2];
    path_base = pop_cnt;
    path_len  = len;
  endtask

  task automatic exp_step(input logic [3:0] x, input logic [3:0] y, input logic [1:0] dir,
                          input logic [7:0] idx);
    step_t e;
    e.x   = x;
    e.y   = y;
    e.dir = dir;
    e.idx = idx;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    step_t e;
    forever begin
      @(negedge clk);
      if (move_rd) begin
        rd_seen++;
        check("rd_when_empty", 32'(move_empty), 32'd0);
      end
      if (step_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 32'(step_idx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q[0];
          check("step_x", 32'(step_x), 32'(e.x));
          check("step_y", 32'(step_y), 32'(e.y));
          check("step_dir", 32'(step_dir), 32'(e.dir));
          check("step_idx", 32'(step_idx), 32'(e.idx));
          if (step_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!step_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_valid", 32'(step_valid), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_done", 32'(done), 32'd1);
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    step_ready = 1'b0;
    path_len   = 0;
    path_base  = 0;
    total      = 0;
    bad        = 0;
    rd_seen    = 0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(step_valid), 32'd0);
    check("rst_x", 32'(step_x), 32'd0);
    check("rst_y", 32'(step_y), 32'd0);
    check("rst_dir", 32'(step_dir), 32'd0);
    check("rst_idx", 32'(step_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Reset while a step is stalled
    load_path(16'h0005, 2);
    exp_step(4'd1, 4'd0, 2'b01, 8'd0);
    pulse_start();
    wait_valid();
    rd0 = rd_seen;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_valid", 32'(step_valid), 32'd0);
    check("mid_rst_x", 32'(step_x), 32'd0);
    check("mid_rst_idx", 32'(step_idx), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rd", 32'(rd_seen - rd0), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_rd", 32'(rd_seen - rd0), 32'd0);
    check("idle_valid", 32'(step_valid), 32'd0);

    // Path 01,01,00,00 with free-flowing downstream
    load_path(16'h0005, 4);
    exp_step(4'd1, 4'd0, 2'b01, 8'd0);
    exp_step(4'd2, 4'd0, 2'b01, 8'd1);
    exp_step(4'd2, 4'd1, 2'b00, 8'd2);
    exp_step(4'd2, 4'd2, 2'b00, 8'd3);
    step_ready = 1'b1;
    rd0 = rd_seen;
    pulse_start();
    wait_done();
    check("p1_err", 32'(err), 32'd0);
    check("p1_rd", 32'(rd_seen - rd0), 32'd4);
    check("p1_left", 32'(exp_q.size()), 32'd0);
    check("p1_valid", 32'(step_valid), 32'd0);

    // Backpressure on the first step
    load_path(16'h0001, 2);
    exp_step(4'd1, 4'd0, 2'b01, 8'd0);
    exp_step(4'd1, 4'd1, 2'b00, 8'd1);
    step_ready = 1'b0;
    rd0 = rd_seen;
    pulse_start();
    wait_valid();
    repeat (5) @(posedge clk);
    #1;
    check("bp_rd", 32'(rd_seen - rd0), 32'd1);
    check("bp_valid", 32'(step_valid), 32'd1);
    step_ready = 1'b1;
    wait_done();
    check("bp_rd_end", 32'(rd_seen - rd0), 32'd2);
    check("bp_left", 32'(exp_q.size()), 32'd0);

    // Empty checklist at start
    load_path(16'h0000, 0);
    rd0 = rd_seen;
    pulse_start();
    check("empty_done_clr", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check("empty_done", 32'(done), 32'd1);
    check("empty_valid", 32'(step_valid), 32'd0);
    check("empty_rd", 32'(rd_seen - rd0), 32'd0);
    check("empty_x", 32'(step_x), 32'd0);
    check("empty_y", 32'(step_y), 32'd0);

    // X-1 from the origin
    load_path(16'h0006, 2);
`ifndef PATH_REPLAYER_BOUNDS_CHECK_EN
    exp_step(4'd15, 4'd0, 2'b10, 8'd0);
    exp_step(4'd0, 4'd0, 2'b01, 8'd1);
`endif
    step_ready = 1'b1;
    rd0 = rd_seen;
    pulse_start();
    wait_done();
`ifdef PATH_REPLAYER_BOUNDS_CHECK_EN
    check("oob_err", 32'(err), 32'd1);
    check("oob_rd", 32'(rd_seen - rd0), 32'd1);
`else
    check("wrap_err", 32'(err), 32'd0);
    check("wrap_rd", 32'(rd_seen - rd0), 32'd2);
`endif
    check("edge_x", 32'(step_x), 32'd0);
    check("edge_y", 32'(step_y), 32'd0);
    check("edge_left", 32'(exp_q.size()), 32'd0);

    // Restart from DONE, with a start pulse ignored during STEP
    load_path(16'h0015, 3);
    exp_step(4'd1, 4'd0, 2'b01, 8'd0);
    exp_step(4'd2, 4'd0, 2'b01, 8'd1);
    exp_step(4'd3, 4'd0, 2'b01, 8'd2);
    step_ready = 1'b0;
    rd0 = rd_seen;
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_err", 32'(err), 32'd0);
    wait_valid();
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    check("ign_start_rd", 32'(rd_seen - rd0), 32'd1);
    check("ign_start_idx", 32'(step_idx), 32'd0);
    step_ready = 1'b1;
    wait_done();
    check("rs_rd", 32'(rd_seen - rd0), 32'd3);
    check("rs_x", 32'(step_x), 32'd3);
    check("rs_err", 32'(err), 32'd0);
    check("rs_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
